// File: rtl/ge_pkg.sv
// Shared definitions for the established-node flag memory: sweep FSM
// states, memory size derivation and read-channel slicing helpers.
package ge_pkg;

   // Sweep controller states
   typedef enum logic {
      GE_IDLE  = 1'b0,
      GE_CLEAR = 1'b1
   } ge_state_t;

   // Legal range for the number of read channels
   localparam int GE_MIN_READ = 1;
   localparam int GE_MAX_READ = 8;

   // Number of entries addressed by an address of the given width
   function automatic int ge_mem_size(input int addr_width);
      return 1 << addr_width;
   endfunction

   // Low bit of channel 'chan' inside a packed per-channel bus
   function automatic int ge_slice_lo(input int chan, input int width);
      return chan * width;
   endfunction

endpackage

// File: rtl/ge_clear_sweep.sv
// Clear-sweep controller: owns the IDLE/CLEAR FSM, the sweep pointer and
// the busy / done indications. Reset (rst_n, asynchronous, active-high)
// parks the controller at the start of a sweep.
module ge_clear_sweep
   import ge_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_req_in,
   output logic                  busy_out,
   output logic                  clear_done_out,
   output logic [ADDR_WIDTH-1:0] clr_ptr_out
);

   localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

   ge_state_t state;

   // Sweep FSM: a request restarts the sweep from entry 0, the last entry ends it
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state          <= GE_CLEAR;
         clr_ptr_out    <= '0;
         busy_out       <= 1'b1;
         clear_done_out <= 1'b0;
      end else begin
         clear_done_out <= 1'b0;
         case (state)
            GE_IDLE: begin
               if (clear_req_in) begin
                  state       <= GE_CLEAR;
                  clr_ptr_out <= '0;
                  busy_out    <= 1'b1;
               end
            end
            GE_CLEAR: begin
               if (clear_req_in) begin
                  // Abandoned sweep: start over, no completion pulse
                  clr_ptr_out <= '0;
               end else if (clr_ptr_out == PTR_LAST) begin
                  state          <= GE_IDLE;
                  clr_ptr_out    <= '0;
                  busy_out       <= 1'b0;
                  clear_done_out <= 1'b1;
               end else begin
                  clr_ptr_out <= clr_ptr_out + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state    <= GE_CLEAR;
               busy_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: rtl/gerenciador_estabelecidos_mc.sv
// Multi-channel established-node flag memory. One write port, N_READ
// registered read channels, hardware clear sweep and a live count of
// non-zero entries. Optional macro GE_RDW_FORWARD_EN makes a read that
// coincides with an IDLE write to the same address return the new data.
module gerenciador_estabelecidos_mc
   import ge_pkg::*;
#(
   parameter int DATA_WIDTH = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int N_READ     = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear_req_in,
   output logic                           busy_out,
   output logic                           clear_done_out,
   input  logic                           write_en_in,
   input  logic [ADDR_WIDTH-1:0]          write_addr_in,
   input  logic [DATA_WIDTH-1:0]          write_data_in,
   output logic                           write_drop_out,
   input  logic [N_READ-1:0]              read_en_in,
   input  logic [N_READ*ADDR_WIDTH-1:0]   read_addr_in,
   output logic [N_READ*DATA_WIDTH-1:0]   read_data_out,
   output logic [N_READ-1:0]              read_valid_out,
   output logic [ADDR_WIDTH:0]            established_count_out
);

   localparam int MEM_SIZE = ge_mem_size(ADDR_WIDTH);

   if (N_READ < GE_MIN_READ || N_READ > GE_MAX_READ) begin : g_bad_n_read
      $error("N_READ must lie between 1 and 8");
   end

   logic [DATA_WIDTH-1:0]                   mem [MEM_SIZE];
   logic [ADDR_WIDTH-1:0]                   clr_ptr;
   logic                                    wr_idle;
   logic                                    old_nz;
   logic                                    new_nz;
   logic [N_READ-1:0][ADDR_WIDTH-1:0]       rd_addr_p0;
   logic [N_READ-1:0][DATA_WIDTH-1:0]       rd_next_p0;
   logic [N_READ-1:0][DATA_WIDTH-1:0]       rd_data_p1;
   logic [N_READ-1:0]                       rd_vld_p1;

   ge_clear_sweep #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_sweep (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear_req_in   (clear_req_in),
      .busy_out       (busy_out),
      .clear_done_out (clear_done_out),
      .clr_ptr_out    (clr_ptr)
   );

   assign wr_idle = write_en_in & ~busy_out;
   assign old_nz  = |mem[write_addr_in];
   assign new_nz  = |write_data_in;

   // Storage: the sweep owns the write port while busy, the scheduler otherwise
   always_ff @(posedge clk) begin
      if (busy_out) begin
         mem[clr_ptr] <= '0;
      end else if (write_en_in) begin
         mem[write_addr_in] <= write_data_in;
      end
   end

   // Unpack per-channel read addresses
   always_comb begin
      rd_addr_p0 = '0;
      for (int k = 0; k < N_READ; k++) begin
         rd_addr_p0[k] = read_addr_in[ge_slice_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      end
   end

   // p0: read-side value per channel; memory is logically empty while busy
   always_comb begin
      rd_next_p0 = '0;
      for (int k = 0; k < N_READ; k++) begin
         if (busy_out) begin
            rd_next_p0[k] = '0;
         end else begin
            rd_next_p0[k] = mem[rd_addr_p0[k]];
`ifdef GE_RDW_FORWARD_EN
            if (write_en_in && (write_addr_in == rd_addr_p0[k])) begin
               rd_next_p0[k] = write_data_in;
            end
`endif
         end
      end
   end

   // p1: registered read results; data holds when a channel is not strobed
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rd_data_p1 <= '0;
         rd_vld_p1  <= '0;
      end else begin
         rd_vld_p1 <= read_en_in;
         for (int k = 0; k < N_READ; k++) begin
            if (read_en_in[k]) begin
               rd_data_p1[k] <= rd_next_p0[k];
            end
         end
      end
   end

   // Established count and dropped-write indication
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         established_count_out <= '0;
         write_drop_out        <= 1'b0;
      end else begin
         write_drop_out <= write_en_in & busy_out;
         if (!busy_out && clear_req_in) begin
            // A same-cycle write is erased by the sweep, so it never counts
            established_count_out <= '0;
         end else if (wr_idle && new_nz && !old_nz) begin
            established_count_out <= established_count_out + (ADDR_WIDTH+1)'(1);
         end else if (wr_idle && !new_nz && old_nz) begin
            established_count_out <= established_count_out - (ADDR_WIDTH+1)'(1);
         end
      end
   end

   assign read_data_out  = rd_data_p1;
   assign read_valid_out = rd_vld_p1;

endmodule

// File: tb/tb_gerenciador_estabelecidos_mc.sv
// Bench for gerenciador_estabelecidos_mc (ADDR_WIDTH=4, DATA_WIDTH=2,
// N_READ=2). Reads are scoreboarded against a behavioural memory model.
module tb_gerenciador_estabelecidos_mc;

   localparam int AW = 4;
   localparam int DW = 2;
   localparam int NR = 2;
   localparam int MS = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              clear_req_in;
   logic              busy_out;
   logic              clear_done_out;
   logic              write_en_in;
   logic [AW-1:0]     write_addr_in;
   logic [DW-1:0]     write_data_in;
   logic              write_drop_out;
   logic [NR-1:0]     read_en_in;
   logic [NR*AW-1:0]  read_addr_in;
   logic [NR*DW-1:0]  read_data_out;
   logic [NR-1:0]     read_valid_out;
   logic [AW:0]       established_count_out;

   gerenciador_estabelecidos_mc #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .N_READ     (NR)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .clear_req_in          (clear_req_in),
      .busy_out              (busy_out),
      .clear_done_out        (clear_done_out),
      .write_en_in           (write_en_in),
      .write_addr_in         (write_addr_in),
      .write_data_in         (write_data_in),
      .write_drop_out        (write_drop_out),
      .read_en_in            (read_en_in),
      .read_addr_in          (read_addr_in),
      .read_data_out         (read_data_out),
      .read_valid_out        (read_valid_out),
      .established_count_out (established_count_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Expected read data per channel, oldest first
   int q0[$];
   int q1[$];

   // Behavioural model: logical memory contents plus sweep bookkeeping
   int m_mem[MS];
   bit m_busy;
   int m_left;
   bit m_done;
   bit m_drop;

   int last_d[NR];
   int mon_got;
   int mon_exp;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < MS; i++) if (m_mem[i] != 0) n++;
      return n;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < MS; i++) m_mem[i] = 0;
      m_busy = 1'b1;
      m_left = MS;
      m_done = 1'b0;
      m_drop = 1'b0;
   endtask

   // One clock of stimulus: drive, predict, advance, compare control outputs
   task automatic cycle(input bit we, input int wa, input int wd, input bit cr,
                        input logic [1:0] re, input int ra0, input int ra1);
      int ra[NR];
      int e;
      write_en_in   = we;
      write_addr_in = AW'(wa);
      write_data_in = DW'(wd);
      clear_req_in  = cr;
      read_en_in    = re;
      read_addr_in  = {AW'(ra1), AW'(ra0)};
      ra[0] = ra0;
      ra[1] = ra1;
      for (int k = 0; k < NR; k++) begin
         if (re[k]) begin
            if (m_busy) e = 0;
            else begin
               e = m_mem[ra[k]];
`ifdef GE_RDW_FORWARD_EN
               if (we && wa == ra[k]) e = wd;
`endif
            end
            if (k == 0) q0.push_back(e);
            else q1.push_back(e);
         end
      end
      m_drop = we && m_busy;
      m_done = 1'b0;
      if (m_busy) begin
         if (cr) m_left = MS;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
            end
         end
      end else begin
         if (we) m_mem[wa] = wd;
         if (cr) begin
            for (int i = 0; i < MS; i++) m_mem[i] = 0;
            m_busy = 1'b1;
            m_left = MS;
         end
      end
      @(posedge clk);
      #1;
      chk("busy_out", busy_out, m_busy);
      chk("clear_done_out", clear_done_out, m_done);
      chk("write_drop_out", write_drop_out, m_drop);
      chk("established_count", established_count_out, model_count());
   endtask

   task automatic idle();
      cycle(0, 0, 0, 0, 2'b00, 0, 0);
   endtask

   task automatic hold_reset(input int n);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         chk("rst_busy", busy_out, 1);
         chk("rst_done", clear_done_out, 0);
         chk("rst_drop", write_drop_out, 0);
         chk("rst_count", established_count_out, 0);
      end
      rst_n = 1'b0;
   endtask

   // Count cycles of busy observed from now until it falls
   task automatic measure_sweep(input string name);
      int bc = 0;
      while (busy_out === 1'b1 && bc < 40) begin
         bc++;
         idle();
      end
      chk(name, bc, MS);
   endtask

   // Monitor: pops the scoreboard whenever a channel presents valid data
   always @(negedge clk) begin
      for (int k = 0; k < NR; k++) begin
         mon_got = int'(read_data_out[k*DW +: DW]);
         if (rst_n) begin
            chk($sformatf("rst_valid ch%0d", k), read_valid_out[k], 0);
            chk($sformatf("rst_data ch%0d", k), mon_got, 0);
            last_d[k] = 0;
         end else if (read_valid_out[k]) begin
            if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid ch%0d: got valid 1 expected 0", k);
            end else begin
               mon_exp = (k == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("read_data ch%0d", k), mon_got, mon_exp);
               last_d[k] = mon_exp;
            end
         end else begin
            chk($sformatf("read_hold ch%0d", k), mon_got, last_d[k]);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_req_in  = 1'b0;
      write_en_in   = 1'b0;
      write_addr_in = '0;
      write_data_in = '0;
      read_en_in    = '0;
      read_addr_in  = '0;
      #1;
      hold_reset(3);

      // Sweep after reset release, then every address reads zero
      measure_sweep("reset_sweep_cycles");
      for (int i = 0; i < MS / 2; i++) cycle(0, 0, 0, 0, 2'b11, 2 * i, 2 * i + 1);

      // Writes to 3, 7, 3 and cross-channel reads
      cycle(1, 3, 1, 0, 2'b00, 0, 0);
      cycle(1, 7, 1, 0, 2'b00, 0, 0);
      cycle(1, 3, 1, 0, 2'b00, 0, 0);
      cycle(0, 0, 0, 0, 2'b11, 7, 3);

      // Write while busy is dropped and leaves no trace
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      cycle(1, 5, 1, 0, 2'b01, 5, 0);
      while (m_busy) idle();
      cycle(0, 0, 0, 0, 2'b11, 5, 5);

      // Read-during-write on the same address, then a plain read
      cycle(1, 9, 1, 0, 2'b01, 9, 0);
      cycle(0, 0, 0, 0, 2'b11, 9, 9);

      // Count to 3, clear, restart mid-sweep at pointer 8
      cycle(1, 2, 1, 0, 2'b00, 0, 0);
      cycle(1, 4, 3, 0, 2'b00, 0, 0);
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      for (int i = 0; i < 8; i++) idle();
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      measure_sweep("restart_sweep_cycles");

      // Zero writes to established and unestablished entries
      cycle(1, 6, 2, 0, 2'b00, 0, 0);
      cycle(1, 6, 3, 0, 2'b00, 0, 0);
      cycle(1, 6, 0, 0, 2'b00, 0, 0);
      cycle(1, 11, 0, 0, 2'b00, 0, 0);

      // Write alongside clear request: performed then erased
      cycle(1, 12, 2, 1, 2'b11, 12, 12);
      while (m_busy) idle();

      // Reset in the middle of a sweep
      cycle(1, 1, 1, 0, 2'b00, 0, 0);
      cycle(0, 0, 0, 1, 2'b00, 0, 0);
      for (int i = 0; i < 5; i++) idle();
      idle();
      hold_reset(2);
      measure_sweep("reset_mid_sweep_cycles");

      // Randomized traffic
      for (int n = 0; n < 1500; n++) begin
         cycle(1'($urandom_range(0, 1)),
               int'($urandom_range(0, MS - 1)),
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 59) == 0),
               2'($urandom_range(0, 3)),
               int'($urandom_range(0, MS - 1)),
               int'($urandom_range(0, MS - 1)));
      end

      idle();
      idle();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
